univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal shift register: serial-in/parallel-out, parallel-in/serial-out,
//   rotate and hold, selected per cycle. Counts shifted bits and publishes each complete
//   serial word on a registered parallel output with a one-cycle valid strobe.
//   Sits between bit-serial links (UART/SPI-style) and word-wide datapaths.
// PARAMETERS
//   WIDTH      8   word width in bits; must be >= 2
//   LSB_FIRST  0   0: shift toward MSB (first bit received ends at MSB); 1: shift toward LSB
//   CW         $clog2(WIDTH)  bit-counter width (localparam, derived, not overridable)
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-low
//   en          in   1      clock enable; 0 = hold everything, word_valid low
//   mode        in   2      00 hold, 01 shift, 10 parallel load, 11 rotate
//   si          in   1      serial data in, sampled in shift mode only
//   pi          in   WIDTH  parallel load data, sampled in load mode only
//   so          out  1      serial out = outgoing bit of shift reg (sr[WIDTH-1] or sr[0])
//   po          out  WIDTH  last completed word, registered
//   word_valid  out  1      one-cycle pulse: po just updated with a new word
//   bit_cnt     out  CW     bits shifted into current word, 0..WIDTH-1
// BEHAVIOUR
//   - All state updates on posedge clk; reset is synchronous and dominates en/mode.
//   - reset==0: sr=0, po=0, word_valid=0, bit_cnt=0; hence so=0 next cycle.
//   - word_valid defaults to 0 every cycle; set only as below.
//   - en==0 or mode==00: sr, po, bit_cnt unchanged; word_valid=0.
//   - mode==01 shift:
//       LSB_FIRST=0: sr <= {sr[WIDTH-2:0], si};  LSB_FIRST=1: sr <= {si, sr[WIDTH-1:1]}.
//       If bit_cnt==WIDTH-1: bit_cnt<=0, po<=shifted sr value (incl. this si), word_valid<=1.
//       Else bit_cnt<=bit_cnt+1 (po unchanged).
//       so presents the bit shifted out this edge before the edge -> PISO use.
//   - mode==10 load: sr<=pi, bit_cnt<=0, po unchanged, word_valid=0 (aborts partial word).
//   - mode==11 rotate: sr rotates 1 bit in the shift direction (outgoing bit re-enters),
//       si ignored, bit_cnt and po unchanged, word_valid=0.
//   - Latency: WIDTH consecutive shift cycles -> po and word_valid valid after the WIDTHth edge.
//   - Gaps (en=0 / hold) between shift bits are allowed; counting resumes where it left off.
//   - Back-to-back words: word_valid may pulse every WIDTH cycles with no dead cycle.
//   - Reset mid-word discards partial word; po cleared to 0.
//   - so is combinational from sr only (no input-to-output path).
//   - No X: all outputs are defined from the first post-reset cycle.
// TESTING
//   1 reset=0 2 cycles, mode/en toggling -> po=0, so=0, bit_cnt=0, word_valid=0.
//   2 WIDTH=8, LSB_FIRST=0, shift si=1,0,1,1,0,0,1,0 -> after 8th edge po=8'hB2, word_valid
//     high exactly 1 cycle, bit_cnt=0.
//   3 Same bits, LSB_FIRST=1 -> po=8'h4D; repeat continuously 3 words -> 3 pulses 8 cycles apart.
//   4 Load pi=8'hA5 then 8 shifts si=0, LSB_FIRST=0 -> so sequence 1,0,1,0,0,1,0,1;
//     word_valid on 8th shift with po=8'h00.
//   5 Shift 5 bits, load 8'h3C, rotate 4 -> sr=8'hC3, bit_cnt=0, no word_valid, po unchanged;
//     en=0 mid-word for 3 cycles -> bit_cnt frozen, word completes after 8 enabled shifts.
//   6 Shift 6 bits then reset=0 one cycle -> bit_cnt=0, po=0; next 8 shifts yield a clean word.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register with four per-cycle modes: hold, shift, parallel
// load and rotate. Each cycle it can take in a serial bit, load a parallel
// word, or rotate in place. When a full word has been shifted in, that word
// is copied to po and word_valid pulses for one cycle.
module univ_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             si,
    input  logic [WIDTH-1:0] pi,
    output logic             so,
    output logic [WIDTH-1:0] po,
    output logic             word_valid,
    output logic [CW-1:0]    bit_cnt
);

    localparam logic [1:0]    MODE_HOLD  = 2'b00;
    localparam logic [1:0]    MODE_SHIFT = 2'b01;
    localparam logic [1:0]    MODE_LOAD  = 2'b10;
    localparam logic [1:0]    MODE_ROT   = 2'b11;
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] sr_rot;

    // Next-value candidates for shift and rotate in the configured direction
    always_comb begin
        if (LSB_FIRST) begin
            sr_shift = {si, sr[WIDTH-1:1]};
            sr_rot   = {sr[0], sr[WIDTH-1:1]};
        end else begin
            sr_shift = {sr[WIDTH-2:0], si};
            sr_rot   = {sr[WIDTH-2:0], sr[WIDTH-1]};
        end
    end

    // Register update; reset dominates, word_valid is a single-cycle strobe
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr         <= '0;
            po         <= '0;
            word_valid <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            word_valid <= 1'b0;
            if (en) begin
                case (mode)
                    MODE_SHIFT: begin
                        sr <= sr_shift;
                        if (bit_cnt == CNT_LAST) begin
                            bit_cnt    <= '0;
                            po         <= sr_shift;
                            word_valid <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    MODE_LOAD: begin
                        // a load abandons any partially shifted word
                        sr      <= pi;
                        bit_cnt <= '0;
                    end
                    MODE_ROT: begin
                        sr <= sr_rot;
                    end
                    MODE_HOLD: begin
                        sr <= sr;
                    end
                    default: begin
                        sr <= sr;
                    end
                endcase
            end
        end
    end

    // Outgoing bit depends only on the register, never on inputs
    assign so = LSB_FIRST ? sr[0] : sr[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg. Two instances run side by side on the same
// stimulus, one shifting toward the MSB and one toward the LSB. A word-level
// arithmetic model predicts every output each cycle, and directed checks pin
// down known words and the cycle spacing of word_valid.
module tb_univ_shift_reg;

    localparam int W    = 8;
    localparam int CW   = $clog2(W);
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          si = 1'b0;
    logic [W-1:0]  pi = '0;

    logic          so0, so1, wv0, wv1;
    logic [W-1:0]  po0, po1;
    logic [CW-1:0] bc0, bc1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model state, index 0 = MSB-first, index 1 = LSB-first
    int m_sr [2];
    int m_po [2];
    int m_cnt[2];
    int m_wv [2];

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W), .LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .si(si), .pi(pi),
        .so(so0), .po(po0), .word_valid(wv0), .bit_cnt(bc0)
    );

    univ_shift_reg #(.WIDTH(W), .LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .si(si), .pi(pi),
        .so(so1), .po(po1), .word_valid(wv1), .bit_cnt(bc1)
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input int m, input bit s, input int p);
        for (int d = 0; d < 2; d++) begin
            m_wv[d] = 0;
            if (!r) begin
                m_sr[d] = 0; m_po[d] = 0; m_cnt[d] = 0;
            end else if (e) begin
                if (m == 1) begin
                    if (d == 0) m_sr[d] = ((m_sr[d] * 2) + s) & MASK;
                    else        m_sr[d] = (m_sr[d] / 2) + (s << (W - 1));
                    if (m_cnt[d] == W - 1) begin
                        m_cnt[d] = 0;
                        m_po[d]  = m_sr[d];
                        m_wv[d]  = 1;
                    end else begin
                        m_cnt[d]++;
                    end
                end else if (m == 2) begin
                    m_sr[d]  = p & MASK;
                    m_cnt[d] = 0;
                end else if (m == 3) begin
                    if (d == 0) m_sr[d] = ((m_sr[d] * 2) & MASK) + (m_sr[d] >> (W - 1));
                    else        m_sr[d] = (m_sr[d] / 2) + ((m_sr[d] % 2) << (W - 1));
                end
            end
        end
    endtask

    task automatic compare_all();
        check("so0",  int'(so0), m_sr[0] >> (W - 1));
        check("so1",  int'(so1), m_sr[1] % 2);
        check("po0",  int'(po0), m_po[0]);
        check("po1",  int'(po1), m_po[1]);
        check("wv0",  int'(wv0), m_wv[0]);
        check("wv1",  int'(wv1), m_wv[1]);
        check("cnt0", int'(bc0), m_cnt[0]);
        check("cnt1", int'(bc1), m_cnt[1]);
    endtask

    // apply one cycle of stimulus, advance the model, compare after the edge
    task automatic step(input bit r, input bit e, input logic [1:0] m, input bit s, input logic [W-1:0] p);
        @(negedge clk);
        reset = r; en = e; mode = m; si = s; pi = p;
        @(posedge clk);
        cyc++;
        model_step(r, e, int'(m), s, int'(p));
        #1;
        compare_all();
    endtask

    task automatic shift_bit(input bit s);
        step(1'b1, 1'b1, 2'b01, s, W'($urandom));
    endtask

    logic [W-1:0] pat;
    logic [W-1:0] so_seq;
    int pulse_cyc[$];

    initial begin
        pat = 8'b0100_1101; // pat[i] is the i-th serial bit: 1,0,1,1,0,0,1,0

        // 1: reset held two cycles with en/mode toggling
        step(1'b0, 1'b1, 2'b01, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 2'b10, 1'b1, 8'hFF);
        check("rst_po",  int'(po0), 0);
        check("rst_so",  int'(so0), 0);
        check("rst_cnt", int'(bc0), 0);
        check("rst_wv",  int'(wv0), 0);

        // 2 and 3: single word in both directions, then three back-to-back words
        for (int i = 0; i < W; i++) shift_bit(pat[i]);
        check("w_msb_po", int'(po0), 'hB2);
        check("w_lsb_po", int'(po1), 'h4D);
        check("w_wv",     int'(wv0), 1);
        check("w_cnt",    int'(bc0), 0);
        step(1'b1, 1'b1, 2'b00, 1'b0, 8'h00);
        check("w_wv_one", int'(wv0), 0);

        pulse_cyc.delete();
        for (int k = 0; k < 3 * W; k++) begin
            shift_bit(pat[k % W]);
            if (wv1) pulse_cyc.push_back(cyc);
        end
        check("b2b_pulses", pulse_cyc.size(), 3);
        if (pulse_cyc.size() == 3) begin
            check("b2b_gap1", pulse_cyc[1] - pulse_cyc[0], W);
            check("b2b_gap2", pulse_cyc[2] - pulse_cyc[1], W);
        end
        check("b2b_po", int'(po1), 'h4D);

        // 4: parallel load then serialise with zeros shifted in
        step(1'b1, 1'b1, 2'b10, 1'b1, 8'hA5);
        for (int i = W - 1; i >= 0; i--) begin
            so_seq[i] = so0;
            shift_bit(1'b0);
        end
        check("piso_so_seq", int'(so_seq), 'hA5);
        check("piso_wv",     int'(wv0), 1);
        check("piso_po",     int'(po0), 'h00);

        // 5: partial word, load, rotate, then gapped shifting
        for (int i = 0; i < 5; i++) shift_bit(1'b1);
        step(1'b1, 1'b1, 2'b10, 1'b0, 8'h3C);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b11, 1'b1, 8'h00);
        check("rot_cnt", int'(bc0), 0);
        check("rot_wv",  int'(wv0), 0);
        check("rot_so0", int'(so0), 1);
        check("rot_so1", int'(so1), 1);
        check("rot_po",  int'(po0), 'h00);
        for (int i = 0; i < 3; i++) shift_bit(pat[i]);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'b01, 1'b1, 8'hFF);
            check("gap_cnt", int'(bc0), 3);
        end
        for (int i = 3; i < W; i++) shift_bit(pat[i]);
        check("gap_wv",  int'(wv0), 1);
        check("gap_po0", int'(po0), 'hB2);
        check("gap_po1", int'(po1), 'h4D);

        // 6: reset mid-word then a clean word
        for (int i = 0; i < 6; i++) shift_bit(1'b1);
        step(1'b0, 1'b1, 2'b01, 1'b1, 8'h00);
        check("mid_rst_cnt", int'(bc0), 0);
        check("mid_rst_po",  int'(po0), 0);
        for (int i = 0; i < W; i++) shift_bit(pat[W - 1 - i]);
        check("clean_po0", int'(po0), 'h4D);
        check("clean_wv",  int'(wv0), 1);

        // randomized traffic, mostly shifting, occasional reset
        for (int n = 0; n < 1500; n++) begin
            logic [1:0] m;
            int sel;
            sel = $urandom_range(0, 9);
            m = (sel < 6) ? 2'b01 : 2'($urandom_range(0, 3));
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0), m,
                 1'($urandom), W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
